// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package mem_arbiter_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_READ_LATENCY = 1;
  localparam int CNT_WIDTH = 4;

  // IDLE arbitrates, ACCESS waits out the memory latency, RESP carries the ack.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arbState_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick between fetch and data requests.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic   fetchReq,
  input  logic   dataReq,
  input  grant_t lastGrant,
  output logic   pickValid,
  output grant_t pick
);

  // A lone request always wins; a tie goes to whoever was not served last.
  always_comb begin
    pickValid = fetchReq | dataReq;
    pick      = FETCH;
    if (fetchReq && dataReq) begin
      pick = (lastGrant == DATA) ? FETCH : DATA;
    end else if (dataReq) begin
      pick = DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the controller's virtual-address port between instruction fetch and
// data load/store.
//
// Handshake: a requester raises req with stable operands and keeps them until
// its ack. Requests are sampled only in IDLE. The ack is a single-cycle pulse
// in RESP. Read data is valid in the ack cycle and is then held until the next
// read for that requester. Dropping req early never aborts a transaction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetchReq,
  input  logic [ADDR_WIDTH-1:0] fetchAddress,
  output logic                  fetchAck,
  output logic [DATA_WIDTH-1:0] fetchData,
  input  logic                  dataReq,
  input  logic [ADDR_WIDTH-1:0] dataAddress,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  dataWEn,
  output logic                  dataAck,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memDataIn,
  output logic                  memWEn,
  input  logic [DATA_WIDTH-1:0] memDataOut,
  output logic [1:0]            stateDbg
);

  localparam logic [CNT_WIDTH-1:0] READ_CNT = CNT_WIDTH'(READ_LATENCY);

  arbState_t state, stateNext;
  grant_t    sel, lastGrant, pick;
  logic      pickValid;
  logic      grantNow, finishNow;
  logic      isWrite;
  logic [CNT_WIDTH-1:0] cnt;

  assign stateDbg = state;

  rr_arbiter2 u_rr (
    .fetchReq  (fetchReq),
    .dataReq   (dataReq),
    .lastGrant (lastGrant),
    .pickValid (pickValid),
    .pick      (pick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state plus the grant/finish strobes that steer the datapath.
  always_comb begin
    stateNext = state;
    grantNow  = 1'b0;
    finishNow = 1'b0;
    case (state)
      IDLE: begin
        if (pickValid) begin
          grantNow  = 1'b1;
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == CNT_WIDTH'(1)) begin
          finishNow = 1'b1;
          stateNext = RESP;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Memory-side registers, latency counter, response data and ack pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel        <= FETCH;
      lastGrant  <= DATA;
      isWrite    <= 1'b0;
      cnt        <= '0;
      memAddress <= '0;
      memDataIn  <= '0;
      memWEn     <= 1'b0;
      fetchAck   <= 1'b0;
      dataAck    <= 1'b0;
      fetchData  <= '0;
      dataOut    <= '0;
    end else begin
      fetchAck <= 1'b0;
      dataAck  <= 1'b0;
      if (grantNow) begin
        sel        <= pick;
        lastGrant  <= pick;
        memAddress <= (pick == DATA) ? dataAddress : fetchAddress;
        memDataIn  <= (pick == DATA) ? dataIn : '0;
        memWEn     <= (pick == DATA) && dataWEn;
        isWrite    <= (pick == DATA) && dataWEn;
        // A write needs no read-back wait, so it completes after one cycle.
        cnt        <= ((pick == DATA) && dataWEn) ? CNT_WIDTH'(1) : READ_CNT;
      end else if (state == ACCESS) begin
        memWEn <= 1'b0;
        cnt    <= cnt - CNT_WIDTH'(1);
        if (finishNow) begin
          if (!isWrite) begin
            if (sel == FETCH) fetchData <= memDataOut;
            else              dataOut   <= memDataOut;
          end
          fetchAck <= (sel == FETCH);
          dataAck  <= (sel == DATA);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 with READ_LATENCY=1, instance 1 with 3.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchReq[2], dataReq[2], dataWEn[2];
  logic        fetchAck[2], dataAck[2], memWEn[2];
  logic [31:0] fetchAddress[2], dataAddress[2], dataIn[2];
  logic [31:0] fetchData[2], dataOut[2], memAddress[2], memDataIn[2], memDataOut[2];
  logic [1:0]  stateDbg[2];
  bit          memAuto[2];
  logic [31:0] memConst[2];

  int checks = 0;
  int passes = 0;
  int lat[2] = '{1, 3};
  int lastServed[2];
  logic [31:0] expFetchData[2], expDataOut[2];

  // Clock and memory behaviour.
  always #5 clk = ~clk;

  function automatic logic [31:0] memHash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign memDataOut[0] = memAuto[0] ? memHash(memAddress[0]) : memConst[0];
  assign memDataOut[1] = memAuto[1] ? memHash(memAddress[1]) : memConst[1];

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1)) dut0 (
    .clk(clk), .rst(rst),
    .fetchReq(fetchReq[0]), .fetchAddress(fetchAddress[0]), .fetchAck(fetchAck[0]), .fetchData(fetchData[0]),
    .dataReq(dataReq[0]), .dataAddress(dataAddress[0]), .dataIn(dataIn[0]), .dataWEn(dataWEn[0]),
    .dataAck(dataAck[0]), .dataOut(dataOut[0]),
    .memAddress(memAddress[0]), .memDataIn(memDataIn[0]), .memWEn(memWEn[0]), .memDataOut(memDataOut[0]),
    .stateDbg(stateDbg[0])
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3)) dut1 (
    .clk(clk), .rst(rst),
    .fetchReq(fetchReq[1]), .fetchAddress(fetchAddress[1]), .fetchAck(fetchAck[1]), .fetchData(fetchData[1]),
    .dataReq(dataReq[1]), .dataAddress(dataAddress[1]), .dataIn(dataIn[1]), .dataWEn(dataWEn[1]),
    .dataAck(dataAck[1]), .dataOut(dataOut[1]),
    .memAddress(memAddress[1]), .memDataIn(memDataIn[1]), .memWEn(memWEn[1]), .memDataOut(memDataOut[1]),
    .stateDbg(stateDbg[1])
  );

  // Reference model state after a reset: fetch wins the first tie, data regs cleared.
  task automatic resetModel();
    for (int u = 0; u < 2; u++) begin
      lastServed[u]   = 1;
      expFetchData[u] = 32'h0;
      expDataOut[u]   = 32'h0;
    end
  endtask

  task automatic randFetch(input int u);
    fetchAddress[u] = $urandom();
  endtask

  task automatic randData(input int u);
    dataAddress[u] = $urandom();
    dataIn[u]      = $urandom();
    dataWEn[u]     = 1'($urandom_range(0, 1));
  endtask

  // Driver + model: starts at a negedge in IDLE, raises the requested reqs and
  // follows every grant to its ack, checking the memory port and response.
  task automatic serve(input int u, input bit wantF, input bit wantD, input int rounds,
                       input bit rearm, input bit allowDrop);
    bit pendF, pendD, winD, wen, dropEarly, gotAck;
    logic [31:0] addr, wdata, rdVal;
    int k, done, expLat;
    pendF = wantF;
    pendD = wantD;
    fetchReq[u] = wantF;
    dataReq[u]  = wantD;
    done = 0;
    while (done < rounds && (pendF || pendD)) begin
      winD      = (pendF && pendD) ? (lastServed[u] == 0) : pendD;
      addr      = winD ? dataAddress[u] : fetchAddress[u];
      wdata     = winD ? dataIn[u] : 32'h0;
      wen       = winD && dataWEn[u];
      expLat    = wen ? 2 : lat[u] + 1;
      rdVal     = memAuto[u] ? memHash(addr) : memConst[u];
      dropEarly = allowDrop && ($urandom_range(0, 2) == 0);
      k = 0;
      gotAck = 0;
      while (!gotAck && k < 40) begin
        @(negedge clk);
        k++;
        checks++;
        if (memAddress[u] !== addr) $display("FAIL mem_address u%0d k%0d: got %h want %h", u, k, memAddress[u], addr);
        else passes++;
        checks++;
        if (memDataIn[u] !== wdata) $display("FAIL mem_data_in u%0d k%0d: got %h want %h", u, k, memDataIn[u], wdata);
        else passes++;
        checks++;
        if (memWEn[u] !== (wen && k == 1)) $display("FAIL mem_wen u%0d k%0d: got %b want %b", u, k, memWEn[u], wen && k == 1);
        else passes++;
        checks++;
        if ((fetchAck[u] & dataAck[u]) !== 1'b0) $display("FAIL both_acks u%0d k%0d: got fetch=%b data=%b want not both", u, k, fetchAck[u], dataAck[u]);
        else passes++;
        if (k == 1 && dropEarly) begin
          if (winD) dataReq[u] = 1'b0;
          else      fetchReq[u] = 1'b0;
        end
        if (fetchAck[u] === 1'b1 || dataAck[u] === 1'b1) gotAck = 1;
      end
      checks++;
      if (k !== expLat) $display("FAIL ack_latency u%0d: got %0d cycles want %0d", u, k, expLat);
      else passes++;
      checks++;
      if ({fetchAck[u], dataAck[u]} !== (winD ? 2'b01 : 2'b10))
        $display("FAIL ack_select u%0d: got fetch=%b data=%b want %s", u, fetchAck[u], dataAck[u], winD ? "data" : "fetch");
      else passes++;
      if (!wen) begin
        if (winD) expDataOut[u] = rdVal;
        else      expFetchData[u] = rdVal;
      end
      lastServed[u] = winD;
      checks++;
      if (fetchData[u] !== expFetchData[u]) $display("FAIL fetch_data u%0d: got %h want %h", u, fetchData[u], expFetchData[u]);
      else passes++;
      checks++;
      if (dataOut[u] !== expDataOut[u]) $display("FAIL data_out u%0d: got %h want %h", u, dataOut[u], expDataOut[u]);
      else passes++;
      done++;
      if (winD) pendD = 0;
      else      pendF = 0;
      if (rearm && done < rounds) begin
        if (winD) begin randData(u); dataReq[u] = 1'b1; pendD = 1; end
        else begin randFetch(u); fetchReq[u] = 1'b1; pendF = 1; end
      end else begin
        if (winD) dataReq[u] = 1'b0;
        else      fetchReq[u] = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (stateDbg[u] !== IDLE || fetchAck[u] !== 1'b0 || dataAck[u] !== 1'b0)
        $display("FAIL after_resp u%0d: got state=%0d acks=%b%b want idle, no ack", u, stateDbg[u], fetchAck[u], dataAck[u]);
      else passes++;
    end
    fetchReq[u] = 1'b0;
    dataReq[u]  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      fetchReq[u] = 1'b0; dataReq[u] = 1'b0; dataWEn[u] = 1'b0;
      fetchAddress[u] = 32'h0; dataAddress[u] = 32'h0; dataIn[u] = 32'h0;
      memAuto[u] = 1'b1; memConst[u] = 32'h0;
    end
    resetModel();
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({fetchAck[u], dataAck[u], memWEn[u]} !== 3'b000) $display("FAIL reset_strobes u%0d: got %b want 000", u, {fetchAck[u], dataAck[u], memWEn[u]});
      else passes++;
      checks++;
      if (memAddress[u] !== 32'h0 || memDataIn[u] !== 32'h0) $display("FAIL reset_mem u%0d: got %h/%h want 0/0", u, memAddress[u], memDataIn[u]);
      else passes++;
      checks++;
      if (fetchData[u] !== 32'h0 || dataOut[u] !== 32'h0) $display("FAIL reset_data u%0d: got %h/%h want 0/0", u, fetchData[u], dataOut[u]);
      else passes++;
      checks++;
      if (stateDbg[u] !== IDLE) $display("FAIL reset_state u%0d: got %0d want %0d", u, stateDbg[u], IDLE);
      else passes++;
    end
    rst = 1'b1;
  endtask

  // Both requests held with fresh operands after each ack: must alternate fetch/data.
  task automatic test_contention(input int u);
    memAuto[u] = 1'b1;
    randFetch(u);
    randData(u);
    serve(u, 1'b1, 1'b1, 8, 1'b1, 1'b0);
  endtask

  task automatic test_single_fetch();
    memAuto[0] = 1'b0;
    memConst[0] = 32'hdead_beef;
    fetchAddress[0] = 32'h0000_0004;
    serve(0, 1'b1, 1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_store();
    memAuto[0] = 1'b0;
    memConst[0] = 32'h0bad_f00d;
    dataAddress[0] = 32'h1000_0008;
    dataIn[0] = 32'h1234_5678;
    dataWEn[0] = 1'b1;
    serve(0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_latency3_load();
    memAuto[1] = 1'b0;
    memConst[1] = 32'hfefe_fefe;
    dataAddress[1] = 32'hffff_000c;
    dataIn[1] = 32'h5555_aaaa;
    dataWEn[1] = 1'b0;
    serve(1, 1'b0, 1'b1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random(input int u, input int n);
    bit wf, wd;
    int gap;
    memAuto[u] = 1'b1;
    for (int i = 0; i < n; i++) begin
      wf = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      if (!wf && !wd) wf = 1'b1;
      randFetch(u);
      randData(u);
      serve(u, wf, wd, 2, 1'b0, 1'b1);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if (stateDbg[u] !== IDLE || fetchAck[u] !== 1'b0 || dataAck[u] !== 1'b0)
          $display("FAIL idle_gap u%0d: got state=%0d acks=%b%b want idle, no ack", u, stateDbg[u], fetchAck[u], dataAck[u]);
        else passes++;
      end
    end
  endtask

  // Reset in the first ACCESS cycle of a store: abort, then fetch wins the next tie.
  task automatic test_reset_mid();
    memAuto[0] = 1'b1;
    dataAddress[0] = 32'h2000_0010;
    dataIn[0] = 32'hcafe_0001;
    dataWEn[0] = 1'b1;
    dataReq[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (memWEn[0] !== 1'b1 || stateDbg[0] !== ACCESS) $display("FAIL mid_pre u0: got wen=%b state=%0d want 1/%0d", memWEn[0], stateDbg[0], ACCESS);
    else passes++;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (memWEn[0] !== 1'b0 || stateDbg[0] !== IDLE || dataAck[0] !== 1'b0)
      $display("FAIL mid_abort u0: got wen=%b state=%0d ack=%b want 0/0/0", memWEn[0], stateDbg[0], dataAck[0]);
    else passes++;
    dataReq[0] = 1'b0;
    resetModel();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dataAck[0] !== 1'b0 || fetchAck[0] !== 1'b0 || dataOut[0] !== 32'h0)
        $display("FAIL mid_quiet u0: got acks=%b%b dataOut=%h want 00/0", fetchAck[0], dataAck[0], dataOut[0]);
      else passes++;
    end
    randFetch(0);
    randData(0);
    dataWEn[0] = 1'b0;
    serve(0, 1'b1, 1'b1, 2, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_contention(0);
    test_contention(1);
    test_single_fetch();
    test_store();
    test_latency3_load();
    test_random(0, 40);
    test_random(1, 40);
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single virtual-address port of the memory controller between two requesters: instruction fetch (read-only) and data load/store (read/write).
- Uses a per-requester req/ack handshake, round-robin arbitration and a latency counter that matches the synchronous RAM/IO read delay behind the controller.
- Sits between the CPU core and the memory controller's Virt-side port (address, dataIn, dataOut, wEn).

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- READ_LATENCY, 1, clock cycles from address presentation to valid memDataOut. Legal range is 1..15; the counter is 4 bits wide.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- fetchReq  input  1  fetch request; held high until fetchAck.
- fetchAddress  input  ADDR_WIDTH  fetch address; stable while fetchReq is high.
- fetchAck  output  1  one-cycle pulse; fetchData is valid in this cycle.
- fetchData  output  DATA_WIDTH  registered fetch read data.
- dataReq  input  1  data request; held high until dataAck.
- dataAddress  input  ADDR_WIDTH  data address; stable while dataReq is high.
- dataIn  input  DATA_WIDTH  store data; stable while dataReq is high.
- dataWEn  input  1  1 = store, 0 = load; stable while dataReq is high.
- dataAck  output  1  one-cycle pulse on completion of a load or store.
- dataOut  output  DATA_WIDTH  registered load data.
- memAddress  output  ADDR_WIDTH  to controller addressVirt.
- memDataIn  output  DATA_WIDTH  to controller dataInVirt.
- memWEn  output  1  to controller wEnVirt.
- memDataOut  input  DATA_WIDTH  from controller dataOutVirt.

Behaviour:
- Reset (rst low, async): state is IDLE and all outputs are 0. lastGrant is set to DATA, so fetch wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no request is present, stay in IDLE; memWEn = 0.
  - If exactly one request is present, grant it.
  - If both are present, grant the requester that is not lastGrant.
  - On the granting edge: register memAddress from the winner. Register memDataIn = dataIn and memWEn = dataWEn for a data grant, or memDataIn = 0 and memWEn = 0 for a fetch grant. Set sel and lastGrant to the winner, load cnt = READ_LATENCY for a read or 1 for a write, then go to ACCESS.
- ACCESS:
  - cnt decrements each cycle. memAddress and memDataIn are held.
  - memWEn is high only during the first ACCESS cycle; clear it on the first ACCESS edge.
  - When cnt == 1, on the next edge:
    - For a read, capture memDataOut into the selected requester's data register (fetchData or dataOut).
    - Set the selected ack, then go to RESP.
- RESP:
  - The selected ack is high for exactly this cycle, then the FSM returns to IDLE.
  - Arbitration never happens in RESP. This lets the requester drop req on the edge that ends ack.
- Latency: the ack rises READ_LATENCY+1 cycles after the granting edge for a read, and 2 cycles after it for a write.
- Throughput: at most one transaction per READ_LATENCY+2 cycles.
- fetchData and dataOut hold their last value until the next read completes for that requester. A write never alters dataOut.
- A req that deasserts mid-transaction does not abort it. The transaction completes and the ack still pulses.
- Requests that arrive in ACCESS or RESP wait. They are sampled only in IDLE.
- With both requests held continuously, grants alternate fetch, data, fetch, data, and so on. No requester starves.
- Reset asserted mid-transaction aborts immediately: no ack, memWEn drops to 0, and no data register updates.
- fetchAck and dataAck are never high in the same cycle.

Decomposition:
- Shared package: FSM state encodings (IDLE, ACCESS, RESP), the grant encodings (FETCH, DATA), and the default widths.
- One sub-module, rr_arbiter2: combinational 2-way round-robin pick from two req bits and lastGrant. All other logic stays in mem_arbiter.

Test Plan:
- Single fetch, READ_LATENCY=1: fetchReq=1, fetchAddress=0x0000_0004, memDataOut=0xdeadbeef → memAddress=0x4 one cycle after grant; fetchAck pulses 2 cycles after grant with fetchData=0xdeadbeef; dataAck stays 0.
- Store: dataReq=1, dataWEn=1, dataAddress=0x1000_0008, dataIn=0x12345678 → memWEn high for exactly 1 cycle with memAddress=0x1000_0008 and memDataIn=0x12345678; dataAck 2 cycles after grant; dataOut unchanged.
- Contention after reset: fetchReq and dataReq both held with operands held → grant order fetch, data, fetch, data; acks alternate; no cycle has both acks high.
- READ_LATENCY=3, load from 0xffff_000c with memDataOut=0xfefefefe → dataAck 4 cycles after grant, dataOut=0xfefefefe; memAddress held through all ACCESS cycles.
- Reset mid-ACCESS on a store: rst pulsed low during the first ACCESS cycle → memWEn=0 immediately, no ack, state IDLE; the next fetch request is granted first.
